rr_sel_arbiter: RTL and testbench

- Round-robin arbiter and output register that sits directly upstream of the team's 4:1 data mux.
- Watches four valid/ready request channels and picks one per transfer.
- Drives the 2-bit select code and registers the selected DATA_W-bit word, with a valid/ready handshake toward the consumer.
- Gives the combinational mux stage a stable, registered, fairly arbitrated select.

---
 rtl/rr_sel_pkg.sv | 11 +
 rtl/rr_pick4.sv | 24 ++
 rtl/rr_sel_arbiter.sv | 104 ++++++++++
 tb/tb_rr_sel_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rr_sel_pkg.sv
// Shared constants and types for the round-robin select arbiter.
package rr_sel_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NUM_CH = 4;

  typedef enum logic {IDLE, FULL} state_e;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority picker: first valid channel at or after start, wrapping 3 -> 0.
module rr_pick4
  import rr_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] in_valid,
  input  sel_t              start,
  output sel_t              gnt_idx,
  output logic              gnt_any
);

  always_comb begin
    gnt_idx = start;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_t idx;
      idx = start + sel_t'(k);
      if (!gnt_any && in_valid[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Four-channel arbiter with a registered select/data output stage.
// Define RR_SEL_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic              out_valid,
  input  logic              out_ready,
  output sel_t              out_sel,
  output logic [DATA_W-1:0] out_data
);

  state_e            state_q, state_d;
  sel_t              sel_q;
  logic [DATA_W-1:0] data_q;
  sel_t              start;
  sel_t              gnt_idx;
  logic              gnt_any;
  logic              load;
  logic [DATA_W-1:0] gnt_data;

`ifdef RR_SEL_FIXED_PRIO_EN
  assign start = '0;
`else
  sel_t last_gnt_q;

  assign start = last_gnt_q + sel_t'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 2'b11;
    end else if (load) begin
      last_gnt_q <= gnt_idx;
    end
  end
`endif

  rr_pick4 u_pick (
    .in_valid (in_valid),
    .start    (start),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // A new word may enter whenever the output slot is empty or being drained.
  assign load = gnt_any && ((state_q == IDLE) || out_ready);

  always_comb begin
    unique case (gnt_idx)
      2'd0:    gnt_data = in0;
      2'd1:    gnt_data = in1;
      2'd2:    gnt_data = in2;
      default: gnt_data = in3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load) state_d = FULL;
      FULL: if (out_ready && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = '0;
    if (load) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      data_q <= '0;
    end else if (load) begin
      sel_q  <= gnt_idx;
      data_q <= gnt_data;
    end
  end

  assign out_sel  = sel_q;
  assign out_data = data_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench for rr_sel_arbiter; the grant model follows RR_SEL_FIXED_PRIO_EN too.
module tb_rr_sel_arbiter;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    in_valid = '0;
  logic [3:0]    in_ready;
  logic [DW-1:0] din [4];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_sel;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]    sel;
    logic [DW-1:0] data;
  } xfer_t;

  xfer_t sb_q[$];

  logic          mdl_valid = 1'b0;
  logic [1:0]    mdl_last  = 2'b11;
  logic [1:0]    mdl_sel   = 2'b00;
  logic [DW-1:0] mdl_data  = '0;

  always #5 clk = ~clk;

  rr_sel_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check in_ready before the edge, check outputs after it.
  task automatic step(input logic [3:0] v, input logic r);
    logic       ld;
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    xfer_t      x;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    #1;
    found = 1'b0;
    idx   = 2'b00;
    for (int k = 0; k < 4; k++) begin
`ifdef RR_SEL_FIXED_PRIO_EN
      cand = 2'(k);
`else
      cand = 2'(mdl_last + 2'(k + 1));
`endif
      if (!found && v[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    ld = found && (!mdl_valid || r);
    check("in_ready", 32'(in_ready), ld ? 32'(4'b0001 << idx) : 32'd0);
    if (ld) sb_q.push_back('{sel: idx, data: din[idx]});
    @(posedge clk);
    #1;
    if (ld) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        x         = sb_q.pop_front();
        mdl_sel   = x.sel;
        mdl_data  = x.data;
        mdl_valid = 1'b1;
        mdl_last  = x.sel;
      end
    end else if (r) begin
      mdl_valid = 1'b0;
    end
    check("out_valid", 32'(out_valid), 32'(mdl_valid));
    check("out_sel", 32'(out_sel), 32'(mdl_sel));
    check("out_data", 32'(out_data), 32'(mdl_data));
  endtask

  initial begin
    din[0] = 4'h1; din[1] = 4'h2; din[2] = 4'h3; din[3] = 4'h4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sel", 32'(out_sel), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All channels requesting: rotate 0,1,2,3,0 (fixed build: always 0).
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1);
`ifndef RR_SEL_FIXED_PRIO_EN
    check("rot_wrap_sel", 32'(out_sel), 32'd0);
    check("rot_wrap_data", 32'(out_data), 32'h1);
`endif

    // Alternating pair 1/3.
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b1);

    // Backpressure: output frozen, no grant.
    step(4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);

    // Same-cycle replacement on channel 2.
    step(4'b0100, 1'b1);
    din[2] = 4'hA;
    step(4'b0100, 1'b1);
    check("replace_sel", 32'(out_sel), 32'd2);
    check("replace_data", 32'(out_data), 32'hA);
    check("replace_valid", 32'(out_valid), 32'd1);

    // Drain then idle.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Asynchronous reset mid-transfer.
    step(4'b0010, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_sel", 32'(out_sel), 32'd0);
    sb_q.delete();
    mdl_valid = 1'b0;
    mdl_last  = 2'b11;
    mdl_sel   = 2'b00;
    mdl_data  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1000, 1'b1);
    check("post_rst_sel", 32'(out_sel), 32'd3);

    // Two-channel contention: fixed build always picks 1, round-robin alternates.
    for (int i = 0; i < 4; i++) step(4'b0110, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      din[i % 4] = DW'($urandom);
      step(4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
